axi4lite_reg_loader: RTL and testbench
======================================

AXI4LITE_REG_LOADER -- requirements
Module: axi4lite_reg_loader

Interface
REQ-001 Parameters: NUM_ENTRIES, default 50, number of registers loaded; ADDR_WIDTH, default 8, AXI address width; BASE_ADDR, default 0, address of entry 0; TIMEOUT, default 1023, maximum cycles waited per handshake.
REQ-002 Ports:
- ACLK  in  1  clock.
- ARESETN  in  1  reset; asynchronous, active-low.
- start  in  1  one-cycle pulse that launches a load.
- verify_en  in  1  readback enable, sampled on start.
- tbl_idx  out  6  table entry index.
- tbl_data  in  32  table word, valid 1 cycle after tbl_idx is presented.
- busy  out  1  load in progress.
- done  out  1  one-cycle completion pulse.
- resp_err  out  1  a non-OKAY BRESP or RRESP was seen.
- cmp_err  out  1  readback mismatch seen.
- timeout  out  1  a handshake exceeded TIMEOUT.
- err_count  out  6  count of failing entries.
- first_err_idx  out  6  index of the first failing entry.
- M_AXI_AWADDR/AWPROT/AWVALID/AWREADY, WDATA/WSTRB/WVALID/WREADY, BRESP/BVALID/BREADY, ARADDR/ARPROT/ARVALID/ARREADY, RDATA/RRESP/RVALID/RREADY: standard AXI4-Lite master channels, 32-bit data.

Function
REQ-003 States are IDLE, WR_FETCH, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE.
REQ-004 IDLE, start=1: clear all error outputs and err_count; latch verify_en; set idx=0; go to WR_FETCH; busy=1 from the next cycle.
REQ-005 start while busy=1 is ignored.
REQ-006 WR_FETCH: tbl_idx=idx held for 1 cycle; tbl_data is registered; go to WR_REQ.
REQ-007 WR_REQ: assert AWVALID and WVALID in the same cycle.
- AWADDR=BASE_ADDR+4*idx, WDATA=registered word, WSTRB=4'hF, AWPROT=ARPROT=0.
- Each VALID deasserts on its own handshake (VALID&READY), independently of the other.
- Go to WR_RESP only after both handshakes have occurred, in either order or together.
REQ-008 WR_RESP: BREADY=1; on BVALID:
- BRESP!=OKAY: set resp_err and record the failure.
- If idx<NUM_ENTRIES-1: idx++, go to WR_FETCH.
- Otherwise: idx=0, then go to WR_FETCH for readback if verify was latched, or to DONE if not.
REQ-009 Readback per entry is fetch (re-read table, 1 cycle) -> RD_REQ -> RD_RESP.
- RD_REQ: ARVALID=1, ARADDR as for writes.
- RD_RESP: RREADY=1; on RVALID, RRESP!=OKAY sets resp_err; RDATA!=registered word sets cmp_err.
- Either condition records one failure for that entry.
- Advances idx as in REQ-008; after the last entry go to DONE.
REQ-010 Recording a failure: err_count increments, saturating at 63; first_err_idx loads idx only when err_count was 0.
REQ-011 VALID, once asserted, is held until its handshake, except on timeout abort.
REQ-012 Timeout counter:
- Counts cycles in WR_REQ, WR_RESP, RD_REQ and RD_RESP.
- Resets on each state entry and on each partial handshake in WR_REQ.
- At count=TIMEOUT: set timeout, drop all VALID/READY, go to DONE.
REQ-013 DONE lasts 1 cycle: done=1, busy=0 next cycle, return to IDLE.
- Error outputs hold until the next accepted start.
REQ-014 Width rules: address arithmetic is ADDR_WIDTH modulo; idx compare uses NUM_ENTRIES-1; NUM_ENTRIES must be between 1 and 63.

Reset
REQ-015 ARESETN=0 asynchronously forces:
- state=IDLE.
- All VALID/READY=0.
- busy, done, resp_err, cmp_err, timeout=0.
- err_count, first_err_idx, tbl_idx, idx, timeout counter=0.
- AWADDR/WDATA/ARADDR=0.
REQ-016 Reset mid-transaction abandons it without completing any handshake; after release the block waits in IDLE for start.

Structure
REQ-017 Shared package axi4lite_loader_pkg holds the state enum, the OKAY response constant (2'b00) and the index width constant.
REQ-018 No sub-module is required; the table is external, and a ROM wrapper axi4lite_loader_rom is the natural companion outside this block.

Verification
REQ-019 Directed scenarios against the 50-register AXI4-Lite slave with an always-ready AXI VIP:
- Table i->i+1, verify_en=1: 50 writes to 0x00..0xC4 -> 50 reads match; done pulses; all error outputs 0; err_count=0.
- Slave returns BRESP=SLVERR on entry 7 only -> resp_err=1, err_count=1, first_err_idx=7, load completes all 50 entries.
- Read data corrupted on entries 3 and 9 -> cmp_err=1, err_count=2, first_err_idx=3.
- AWREADY delayed 5 cycles after WREADY, then WREADY delayed 5 cycles after AWREADY -> no duplicate handshakes; write data matches the table.
- ARREADY held low -> timeout=1 after TIMEOUT+1 cycles in RD_REQ; ARVALID drops; done pulses.
- ARESETN pulsed low mid-write at entry 20, then start -> all outputs 0 during reset; fresh load from entry 0 passes.

Source files
------------

// File: rtl/axi4lite_loader_pkg.sv
// -----------------------------------------------------------------------------
// axi4lite_loader_pkg
// Shared definitions for the AXI4-Lite register loader:
//   state_t    - loader sequencing states
//   RESP_OKAY  - AXI OKAY response code
//   IDX_W      - width of the table index / error counters
//   ERR_MAX    - saturation value of the failure counter
// -----------------------------------------------------------------------------
package axi4lite_loader_pkg;

   localparam int          IDX_W     = 6;
   localparam logic [1:0]  RESP_OKAY = 2'b00;
   localparam logic [IDX_W-1:0] ERR_MAX = '1;

   // NOTE: an enum keeps the encoding out of the logic and lets the tools
   // show state names; the width is fixed so the register size is explicit.
   typedef enum logic [2:0] {
      S_IDLE,
      S_WR_FETCH,
      S_WR_REQ,
      S_WR_RESP,
      S_RD_REQ,
      S_RD_RESP,
      S_DONE
   } state_t;

endpackage

// File: rtl/axi4lite_reg_loader.sv
// -----------------------------------------------------------------------------
// axi4lite_reg_loader
// Walks an external table of NUM_ENTRIES 32-bit words, writes each word over
// AXI4-Lite to BASE_ADDR + 4*idx, and optionally reads every register back to
// compare it with the table. Reports response errors, readback mismatches and
// handshake timeouts, counts failing entries and remembers the first one.
//
// Ports:
//   ACLK, ARESETN     clock, asynchronous active-low reset
//   start, verify_en  launch pulse; readback enable sampled with start
//   tbl_idx/tbl_data  table lookup (data valid one cycle after the index)
//   busy, done        load in progress / one-cycle completion pulse
//   resp_err, cmp_err, timeout, err_count, first_err_idx   status
//   M_AXI_*           AXI4-Lite master (AW, W, B, AR, R channels)
// -----------------------------------------------------------------------------
module axi4lite_reg_loader
   import axi4lite_loader_pkg::*;
#(
   parameter int NUM_ENTRIES = 50,
   parameter int ADDR_WIDTH  = 8,
   parameter int BASE_ADDR   = 0,
   parameter int TIMEOUT     = 1023
) (
   input  logic                  ACLK,
   input  logic                  ARESETN,
   input  logic                  start,
   input  logic                  verify_en,
   output logic [5:0]            tbl_idx,
   input  logic [31:0]           tbl_data,
   output logic                  busy,
   output logic                  done,
   output logic                  resp_err,
   output logic                  cmp_err,
   output logic                  timeout,
   output logic [5:0]            err_count,
   output logic [5:0]            first_err_idx,
   output logic [ADDR_WIDTH-1:0] M_AXI_AWADDR,
   output logic [2:0]            M_AXI_AWPROT,
   output logic                  M_AXI_AWVALID,
   input  logic                  M_AXI_AWREADY,
   output logic [31:0]           M_AXI_WDATA,
   output logic [3:0]            M_AXI_WSTRB,
   output logic                  M_AXI_WVALID,
   input  logic                  M_AXI_WREADY,
   input  logic [1:0]            M_AXI_BRESP,
   input  logic                  M_AXI_BVALID,
   output logic                  M_AXI_BREADY,
   output logic [ADDR_WIDTH-1:0] M_AXI_ARADDR,
   output logic [2:0]            M_AXI_ARPROT,
   output logic                  M_AXI_ARVALID,
   input  logic                  M_AXI_ARREADY,
   input  logic [31:0]           M_AXI_RDATA,
   input  logic [1:0]            M_AXI_RRESP,
   input  logic                  M_AXI_RVALID,
   output logic                  M_AXI_RREADY
);

   localparam int TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

   state_t           state;
   logic [IDX_W-1:0] idx;
   logic             verify_q;
   logic             rd_phase;   // 0: write pass, 1: readback pass
   logic [31:0]      word;       // registered table word, doubles as WDATA
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [TW-1:0]    tmo_cnt;

   logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
   logic last, timed, progress, rec_fail, abort;

   function automatic logic [ADDR_WIDTH-1:0] addr_of(input logic [IDX_W-1:0] i);
      return ADDR_WIDTH'(BASE_ADDR + 4 * int'(i));
   endfunction

   assign tbl_idx      = idx;
   assign M_AXI_WDATA  = word;
   assign M_AXI_AWADDR = addr_q;
   assign M_AXI_ARADDR = addr_q;
   assign M_AXI_WSTRB  = 4'hF;
   assign M_AXI_AWPROT = 3'b000;
   assign M_AXI_ARPROT = 3'b000;

   assign aw_hs = M_AXI_AWVALID & M_AXI_AWREADY;
   assign w_hs  = M_AXI_WVALID  & M_AXI_WREADY;
   assign b_hs  = M_AXI_BVALID  & M_AXI_BREADY;
   assign ar_hs = M_AXI_ARVALID & M_AXI_ARREADY;
   assign r_hs  = M_AXI_RVALID  & M_AXI_RREADY;
   assign last  = (idx == IDX_W'(NUM_ENTRIES - 1));

   // NOTE: every signal gets a default before the case so no path leaves a
   // value unassigned, which would otherwise infer a latch.
   always_comb begin
      timed    = 1'b0;
      progress = 1'b0;
      rec_fail = 1'b0;
      case (state)
         S_WR_REQ:  begin timed = 1'b1; progress = aw_hs | w_hs; end
         S_WR_RESP: begin
            timed    = 1'b1;
            progress = b_hs;
            rec_fail = b_hs & (M_AXI_BRESP != RESP_OKAY);
         end
         S_RD_REQ:  begin timed = 1'b1; progress = ar_hs; end
         S_RD_RESP: begin
            timed    = 1'b1;
            progress = r_hs;
            rec_fail = r_hs & ((M_AXI_RRESP != RESP_OKAY) | (M_AXI_RDATA != word));
         end
         default: ;
      endcase
   end

   // A handshake landing on the final count still wins over the abort.
   assign abort = timed & ~progress & (tmo_cnt == TW'(TIMEOUT));

   // NOTE: all state updates use non-blocking assignments so every register
   // samples pre-edge values, independent of statement order.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         state         <= S_IDLE;
         idx           <= '0;
         verify_q      <= 1'b0;
         rd_phase      <= 1'b0;
         word          <= '0;
         addr_q        <= '0;
         tmo_cnt       <= '0;
         M_AXI_AWVALID <= 1'b0;
         M_AXI_WVALID  <= 1'b0;
         M_AXI_BREADY  <= 1'b0;
         M_AXI_ARVALID <= 1'b0;
         M_AXI_RREADY  <= 1'b0;
         busy          <= 1'b0;
         done          <= 1'b0;
         resp_err      <= 1'b0;
         cmp_err       <= 1'b0;
         timeout       <= 1'b0;
         err_count     <= '0;
         first_err_idx <= '0;
      end else begin
         done <= 1'b0;

         // Every entry into a timed state comes from a fetch (counter idle)
         // or through a handshake, so this also covers the entry reset.
         if (timed) tmo_cnt <= progress ? '0 : tmo_cnt + 1'b1;
         else       tmo_cnt <= '0;

         if (rec_fail) begin
            if (err_count == '0)    first_err_idx <= idx;
            if (err_count != ERR_MAX) err_count   <= err_count + 1'b1;
         end

         if (abort) begin
            timeout       <= 1'b1;
            M_AXI_AWVALID <= 1'b0;
            M_AXI_WVALID  <= 1'b0;
            M_AXI_BREADY  <= 1'b0;
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b0;
            done          <= 1'b1;
            state         <= S_DONE;
         end else begin
            case (state)
               S_IDLE: if (start) begin
                  resp_err      <= 1'b0;
                  cmp_err       <= 1'b0;
                  timeout       <= 1'b0;
                  err_count     <= '0;
                  first_err_idx <= '0;
                  verify_q      <= verify_en;
                  rd_phase      <= 1'b0;
                  idx           <= '0;
                  busy          <= 1'b1;
                  state         <= S_WR_FETCH;
               end
               S_WR_FETCH: begin
                  word   <= tbl_data;
                  addr_q <= addr_of(idx);
                  if (rd_phase) begin
                     M_AXI_ARVALID <= 1'b1;
                     state         <= S_RD_REQ;
                  end else begin
                     M_AXI_AWVALID <= 1'b1;
                     M_AXI_WVALID  <= 1'b1;
                     state         <= S_WR_REQ;
                  end
               end
               S_WR_REQ: begin
                  if (aw_hs) M_AXI_AWVALID <= 1'b0;
                  if (w_hs)  M_AXI_WVALID  <= 1'b0;
                  // A channel is finished if it handshakes now or already has.
                  if ((aw_hs | ~M_AXI_AWVALID) & (w_hs | ~M_AXI_WVALID)) begin
                     M_AXI_BREADY <= 1'b1;
                     state        <= S_WR_RESP;
                  end
               end
               S_WR_RESP: if (b_hs) begin
                  M_AXI_BREADY <= 1'b0;
                  if (M_AXI_BRESP != RESP_OKAY) resp_err <= 1'b1;
                  if (!last) begin
                     idx   <= idx + 1'b1;
                     state <= S_WR_FETCH;
                  end else begin
                     idx      <= '0;
                     rd_phase <= 1'b1;
                     done     <= ~verify_q;
                     state    <= verify_q ? S_WR_FETCH : S_DONE;
                  end
               end
               S_RD_REQ: if (ar_hs) begin
                  M_AXI_ARVALID <= 1'b0;
                  M_AXI_RREADY  <= 1'b1;
                  state         <= S_RD_RESP;
               end
               S_RD_RESP: if (r_hs) begin
                  M_AXI_RREADY <= 1'b0;
                  if (M_AXI_RRESP != RESP_OKAY) resp_err <= 1'b1;
                  if (M_AXI_RDATA != word)      cmp_err  <= 1'b1;
                  if (!last) begin
                     idx   <= idx + 1'b1;
                     state <= S_WR_FETCH;
                  end else begin
                     idx   <= '0;
                     done  <= 1'b1;
                     state <= S_DONE;
                  end
               end
               S_DONE: begin
                  busy  <= 1'b0;
                  state <= S_IDLE;
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_axi4lite_reg_loader.sv
// -----------------------------------------------------------------------------
// tb_axi4lite_reg_loader
// Drives the loader against a behavioural AXI4-Lite slave with a 64-word
// register file, configurable READY delays and injectable errors. Expected
// addresses, data and status come from the loader's rules applied to the
// table and the injected error sets.
// -----------------------------------------------------------------------------
module tb_axi4lite_reg_loader;
   import axi4lite_loader_pkg::*;

   localparam int N    = 50;
   localparam int AW   = 8;
   localparam int BASE = 0;
   localparam int TMO  = 1023;

   logic          ACLK = 1'b0;
   logic          ARESETN;
   logic          start, verify_en;
   logic [5:0]    tbl_idx;
   logic [31:0]   tbl_data;
   logic          busy, done, resp_err, cmp_err, timeout;
   logic [5:0]    err_count, first_err_idx;
   logic [AW-1:0] awaddr, araddr;
   logic [2:0]    awprot, arprot;
   logic          awvalid, awready, wvalid, wready, bvalid, bready;
   logic          arvalid, arready, rvalid, rready;
   logic [31:0]   wdata, rdata;
   logic [3:0]    wstrb;
   logic [1:0]    bresp, rresp;

   logic [31:0] tbl [0:63];
   assign tbl_data = tbl[tbl_idx];

   axi4lite_reg_loader #(.NUM_ENTRIES(N), .ADDR_WIDTH(AW), .BASE_ADDR(BASE), .TIMEOUT(TMO)) dut (
      .ACLK(ACLK), .ARESETN(ARESETN), .start(start), .verify_en(verify_en),
      .tbl_idx(tbl_idx), .tbl_data(tbl_data), .busy(busy), .done(done),
      .resp_err(resp_err), .cmp_err(cmp_err), .timeout(timeout),
      .err_count(err_count), .first_err_idx(first_err_idx),
      .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
      .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
      .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
      .M_AXI_ARADDR(araddr), .M_AXI_ARPROT(arprot), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
      .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
   );

   always #5 ACLK = ~ACLK;

   int n_assert = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   // ---------------- behavioural slave ----------------
   logic [31:0] mem [0:63];
   bit   bresp_bad [64], rresp_bad [64], corrupt [64];
   int   fix_aw = 0, fix_w = 0, fix_ar = 0;   // >=0 fixed delay, -1 random, -2 never
   bit   rand_lat = 0;
   bit   aw_pend, w_pend, ar_pend;
   bit   aw_fire, w_fire, b_fire, ar_fire, r_fire;
   bit   prev_awv, prev_wv, prev_arv;
   logic [AW-1:0] aw_a, ar_a;
   logic [31:0]   w_d;
   int   aw_age, w_age, ar_age, aw_dly, w_dly, ar_dly;
   int   aw_seen, w_seen, ar_seen, stuck_len;
   logic [AW-1:0] last_aw;

   function automatic int pick(input int f);
      if (f == -1) return int'($urandom_range(0, 4));
      if (f == -2) return 1 << 30;
      return f;
   endfunction

   function automatic logic [AW-1:0] exp_addr(input int i);
      return AW'(BASE + 4 * i);
   endfunction

   function automatic int slot(input logic [AW-1:0] a);
      return ((int'(a) - BASE) >> 2) & 63;
   endfunction

   always @(negedge ACLK) begin
      if (!ARESETN) begin
         awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
         bresp = 0; rresp = 0; rdata = 0;
         aw_pend = 0; w_pend = 0; ar_pend = 0;
         aw_fire = 0; w_fire = 0; b_fire = 0; ar_fire = 0; r_fire = 0;
         prev_awv = 0; prev_wv = 0; prev_arv = 0;
         aw_age = 0; w_age = 0; ar_age = 0;
      end else begin
         // VALID must stay up until its handshake (AR may drop only on timeout)
         if (prev_awv && !aw_fire) check("awvalid_hold", awvalid, 1);
         if (prev_wv  && !w_fire)  check("wvalid_hold", wvalid, 1);
         if (prev_arv && !ar_fire) check("arvalid_hold", arvalid | timeout, 1);
         if (!arvalid && ar_age > 0 && !ar_fire) stuck_len = ar_age;
         if (b_fire) bvalid = 0;
         if (r_fire) rvalid = 0;

         if (aw_pend && w_pend && !bvalid && !(rand_lat && $urandom_range(0, 2) == 0)) begin
            mem[slot(aw_a)] = w_d;
            bresp  = bresp_bad[slot(aw_a)] ? 2'b10 : 2'b00;
            bvalid = 1;
            aw_pend = 0; w_pend = 0;
         end
         if (ar_pend && !rvalid && !(rand_lat && $urandom_range(0, 2) == 0)) begin
            rdata  = mem[slot(ar_a)] ^ (corrupt[slot(ar_a)] ? 32'h0000_0100 : 32'h0);
            rresp  = rresp_bad[slot(ar_a)] ? 2'b10 : 2'b00;
            rvalid = 1;
            ar_pend = 0;
         end

         if (!awvalid) aw_age = 0; else if (aw_age == 0) aw_dly = pick(fix_aw);
         if (!wvalid)  w_age  = 0; else if (w_age == 0)  w_dly  = pick(fix_w);
         if (!arvalid) ar_age = 0; else if (ar_age == 0) ar_dly = pick(fix_ar);
         awready = awvalid && (aw_age >= aw_dly);
         wready  = wvalid  && (w_age  >= w_dly);
         arready = arvalid && (ar_age >= ar_dly);
         if (awvalid) aw_age++;
         if (wvalid)  w_age++;
         if (arvalid) ar_age++;

         aw_fire = awvalid && awready;
         w_fire  = wvalid && wready;
         ar_fire = arvalid && arready;
         b_fire  = bvalid && bready;
         r_fire  = rvalid && rready;

         if (awvalid) check("axi_attrs", {wstrb, awprot, arprot}, {4'hF, 3'b0, 3'b0});
         if (aw_fire) begin
            check("aw_duplicate", aw_pend, 0);
            check("aw_addr", awaddr, exp_addr(aw_seen));
            aw_pend = 1; aw_a = awaddr; last_aw = awaddr; aw_seen++;
         end
         if (w_fire) begin
            check("w_duplicate", w_pend, 0);
            check("w_data", wdata, tbl[w_seen]);
            w_pend = 1; w_d = wdata; w_seen++;
         end
         if (ar_fire) begin
            check("ar_addr", araddr, exp_addr(ar_seen));
            ar_pend = 1; ar_a = araddr; ar_seen++;
         end
         prev_awv = awvalid; prev_wv = wvalid; prev_arv = arvalid;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic clear_errs();
      for (int i = 0; i < 64; i++) begin
         bresp_bad[i] = 0; rresp_bad[i] = 0; corrupt[i] = 0;
      end
   endtask

   // Runs one load and checks the outcome against the loader's rules.
   task automatic run_load(input bit v, input bit exp_to);
      int fails[$];
      bit got = 0;
      bit any_resp = 0, any_cmp = 0;
      int bad = 0;
      aw_seen = 0; w_seen = 0; ar_seen = 0; stuck_len = 0;
      @(negedge ACLK); start = 1; verify_en = v;
      @(negedge ACLK); start = 0; verify_en = ~v;
      check("busy_after_start", busy, 1);
      for (int c = 0; c < 6000 && !got; c++) begin
         @(negedge ACLK);
         start = (c == 100);           // ignored: load in progress
         if (done) got = 1;
      end
      start = 0;
      check("done_seen", got, 1);

      for (int i = 0; i < N; i++)
         if (bresp_bad[i]) begin fails.push_back(i); any_resp = 1; end
      if (v && !exp_to)
         for (int i = 0; i < N; i++)
            if (rresp_bad[i] || corrupt[i]) begin
               fails.push_back(i);
               if (rresp_bad[i]) any_resp = 1;
               if (corrupt[i])   any_cmp  = 1;
            end
      check("resp_err", resp_err, any_resp);
      check("cmp_err", cmp_err, any_cmp);
      check("timeout", timeout, exp_to);
      check("err_count", err_count, (fails.size() > 63) ? 63 : fails.size());
      check("first_err_idx", first_err_idx, (fails.size() > 0) ? fails[0] : 0);
      check("aw_count", aw_seen, N);
      check("ar_count", ar_seen, (v && !exp_to) ? N : (exp_to ? 0 : 0));
      for (int i = 0; i < N; i++) if (mem[i] !== tbl[i]) bad++;
      check("mem_contents", bad, 0);
      @(negedge ACLK);
      check("done_one_cycle", {done, busy}, 2'b00);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      ARESETN = 0; start = 0; verify_en = 0;
      awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
      bresp = 0; rresp = 0; rdata = 0;
      for (int i = 0; i < 64; i++) begin tbl[i] = 0; mem[i] = 32'hDEAD_0000; end
      clear_errs();
      repeat (3) @(negedge ACLK);
      check("reset_flags", {busy, done, resp_err, cmp_err, timeout,
                            awvalid, wvalid, bready, arvalid, rready}, 0);
      check("reset_counts", {err_count, first_err_idx, tbl_idx}, 0);
      ARESETN = 1;
      repeat (2) @(negedge ACLK);

      // table i -> i+1, always-ready slave, readback on
      for (int i = 0; i < 64; i++) tbl[i] = i + 1;
      run_load(1, 0);
      check("s1_last_awaddr", last_aw, 8'hC4);
      check("s1_err_count", err_count, 0);

      // SLVERR on entry 7 write
      bresp_bad[7] = 1;
      run_load(1, 0);
      check("s2_err_count", err_count, 1);
      check("s2_first_idx", first_err_idx, 7);
      check("s2_resp_err", resp_err, 1);
      clear_errs();

      // read data corrupted on entries 3 and 9
      corrupt[3] = 1; corrupt[9] = 1;
      run_load(1, 0);
      check("s3_err_count", err_count, 2);
      check("s3_first_idx", first_err_idx, 3);
      check("s3_cmp_err", cmp_err, 1);
      clear_errs();

      // skewed AW/W readiness in both directions
      for (int i = 0; i < 64; i++) tbl[i] = $urandom;
      fix_aw = 5; fix_w = 0; run_load(0, 0);
      fix_aw = 0; fix_w = 5; run_load(1, 0);
      fix_w = 0;

      // ARREADY never rises: timeout on the first readback
      fix_ar = -2;
      run_load(1, 1);
      check("s5_arvalid_cycles", stuck_len, TMO + 1);
      check("s5_timeout", timeout, 1);
      fix_ar = 0;

      // every entry fails twice: counter saturates
      for (int i = 0; i < N; i++) begin bresp_bad[i] = 1; corrupt[i] = 1; end
      run_load(1, 0);
      check("sat_err_count", err_count, 63);
      clear_errs();

      // reset mid-write at entry 20
      begin
         bit got = 0;
         aw_seen = 0; w_seen = 0; ar_seen = 0;
         @(negedge ACLK); start = 1; verify_en = 1;
         @(negedge ACLK); start = 0;
         for (int c = 0; c < 2000 && !got; c++) begin
            @(negedge ACLK);
            if (aw_seen == 20 && awvalid) got = 1;
         end
         check("reach_entry20", got, 1);
         check("pre_reset_idx", tbl_idx, 20);
         ARESETN = 0;
         #1;
         check("midrst_flags", {busy, done, resp_err, cmp_err, timeout,
                                awvalid, wvalid, bready, arvalid, rready}, 0);
         check("midrst_regs", {err_count, first_err_idx, tbl_idx, awaddr, araddr, wdata}, 0);
         repeat (2) @(negedge ACLK);
         ARESETN = 1;
         repeat (4) @(negedge ACLK);
         check("idle_after_reset", busy, 0);
         for (int i = 0; i < 64; i++) mem[i] = 32'hDEAD_0000;
         run_load(1, 0);
      end

      // randomized loads
      fix_aw = -1; fix_w = -1; fix_ar = -1; rand_lat = 1;
      for (int r = 0; r < 4; r++) begin
         for (int i = 0; i < 64; i++) begin
            tbl[i]       = $urandom;
            bresp_bad[i] = ($urandom_range(0, 20) == 0);
            rresp_bad[i] = ($urandom_range(0, 20) == 0);
            corrupt[i]   = ($urandom_range(0, 20) == 0);
         end
         run_load(1'($urandom_range(0, 1)), 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
